// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arithmetic ops, shift-add multiply.
// Valid/ready handshake on both request and result sides.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int SW = $clog2(WIDTH);
    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mb;
    logic [SW-1:0]        cnt;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     r;
    logic                 c;
    logic                 v;
    logic                 lt;

    assign in_ready = rst_n && (state == IDLE);
    assign lt = $signed(a) < $signed(b);
    assign acc_nxt = acc + (mb[0] ? mc : '0);

    always_comb begin
        sum = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        unique case (sel)
            3'b000: begin
                sum = {1'b0, a} + {1'b0, b};
                r = sum[M:0];
                c = sum[WIDTH];
                v = (a[M] == b[M]) && (r[M] != a[M]);
            end
            3'b001: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                r = sum[M:0];
                c = sum[WIDTH];
                v = (a[M] != b[M]) && (r[M] != a[M]);
            end
            3'b010: r = a ^ b;
            3'b011: r = {{(WIDTH-1){1'b0}}, lt};
            3'b100: r = ~(a | b);
            3'b101: r = ~(a & b);
            3'b111: r = a << b[SW-1:0];
            default: r = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out_valid <= 1'b0;
            result <= '0;
            carry <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
            negative <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (sel == 3'b110) begin
                            acc <= '0;
                            mc <= {{WIDTH{1'b0}}, a};
                            mb <= b;
                            cnt <= '0;
                            state <= BUSY;
                        end else begin
                            result <= r;
                            carry <= c;
                            overflow <= v;
                            zero <= (r == '0);
                            negative <= r[M];
                            out_valid <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    mc <= mc << 1;
                    mb <= mb >> 1;
                    cnt <= cnt + SW'(1);
                    // last multiplier bit folds straight into the result
                    if (cnt == SW'(WIDTH - 1)) begin
                        result <= acc_nxt[M:0];
                        carry <= |acc_nxt[2*WIDTH-1:WIDTH];
                        overflow <= 1'b0;
                        zero <= (acc_nxt[M:0] == '0);
                        negative <= acc_nxt[M];
                        out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=8.
// Expected values are hand-computed constants.
module tb_alu_iter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;
    int         tests = 0;
    int         failed = 0;
    int         seen;

    alu_iter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic [7:0] r,
                         input logic c, input logic v,
                         input logic z, input logic n);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".res"}, result, r);
        check({tag, ".carry"}, carry, c);
        check({tag, ".ovf"}, overflow, v);
        check({tag, ".zero"}, zero, z);
        check({tag, ".neg"}, negative, n);
    endtask

    task automatic issue(input logic [2:0] s, input logic [7:0] x,
                         input logic [7:0] y);
        sel = s;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'hAA;
        b = 8'h55;
        sel = 3'b010;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".hs_valid"}, out_valid, 0);
        check({tag, ".hs_ready"}, in_ready, 1);
    endtask

    task automatic mul_wait(input string tag);
        for (int i = 1; i < 8; i++) begin
            check({tag, ".busy_valid"}, out_valid, 0);
            check({tag, ".busy_ready"}, in_ready, 0);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = 3'b000;
        a = 8'h00;
        b = 8'h00;
        tick();
        tick();
        check("rst.ready", in_ready, 0);
        check("rst.valid", out_valid, 0);
        check("rst.res", result, 0);
        check("rst.flags", {carry, overflow, zero, negative}, 0);
        rst_n = 1'b1;
        tick();
        check("post.ready", in_ready, 1);
        check("post.valid", out_valid, 0);

        issue(3'b000, 8'h7F, 8'h01);
        flags("add", 8'h80, 0, 1, 0, 1);
        check("add.ready", in_ready, 0);
        handshake("add");

        issue(3'b001, 8'h05, 8'h05);
        flags("sub", 8'h00, 1, 0, 1, 0);
        handshake("sub");

        issue(3'b011, 8'h80, 8'h01);
        flags("slt", 8'h01, 0, 0, 0, 0);
        handshake("slt");

        issue(3'b101, 8'hF0, 8'hFF);
        flags("nand", 8'h0F, 0, 0, 0, 0);
        handshake("nand");

        issue(3'b111, 8'h81, 8'h09);
        flags("sll", 8'h02, 0, 0, 0, 0);
        handshake("sll");

        issue(3'b110, 8'h10, 8'h11);
        mul_wait("mul");
        check("mul.edge7", out_valid, 0);
        tick();
        flags("mul", 8'h10, 1, 0, 0, 0);
        check("mul.done_ready", in_ready, 0);

        sel = 3'b000;
        a = 8'h01;
        b = 8'h02;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            flags("bp", 8'h10, 1, 0, 0, 0);
            check("bp.ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.hs_valid", out_valid, 0);
        check("bp.hs_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        flags("bp.next", 8'h03, 0, 0, 0, 0);
        handshake("bp.next");

        issue(3'b110, 8'h00, 8'hFF);
        mul_wait("mul0");
        tick();
        flags("mul0", 8'h00, 0, 0, 1, 0);
        handshake("mul0");

        issue(3'b110, 8'h10, 8'h11);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst.valid", out_valid, 0);
        check("mrst.res", result, 0);
        check("mrst.flags", {carry, overflow, zero, negative}, 0);
        check("mrst.ready_low", in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("mrst.ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("mrst.no_valid", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits, legal range 2..64.
REQ-002 The block SHALL have the ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 sel  input  3  opcode.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 carry  output  1  carry flag.
REQ-013 overflow  output  1  signed overflow flag.
REQ-014 zero  output  1  result equals 0.
REQ-015 negative  output  1  result MSB.

Function
REQ-016 FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE with rst_n high.
REQ-017 Accept SHALL occur on a rising edge with in_valid && in_ready; sel, a, b SHALL be captured then, and later input changes SHALL have no effect.
REQ-018 Opcodes: 000 ADD a+b; 001 SUB a-b (a+~b+1); 010 XOR; 011 SLT (signed a<b, result 1 or 0 zero-extended); 100 NOR; 101 NAND; 110 MUL (low WIDTH bits of unsigned a*b); 111 SLL (a << b[clog2(WIDTH)-1:0]).
REQ-019 Non-MUL ops: IDLE -> DONE on the accept edge; out_valid SHALL be 1 in the cycle after accept.
REQ-020 MUL: IDLE -> BUSY on accept; iterative shift-add, one bit of b per cycle, with a 2*WIDTH-bit accumulator; BUSY -> DONE on the WIDTH-th edge after accept, so out_valid rises exactly WIDTH cycles after accept.
REQ-021 DONE: result and all flags SHALL hold stable until an edge with out_valid && out_ready, then go to IDLE; in_ready SHALL be 1 the following cycle.
REQ-022 out_ready while out_valid is 0 SHALL be ignored; in_valid outside IDLE SHALL be ignored and not queued.
REQ-023 carry: ADD/SUB = carry out of bit WIDTH-1 (SUB: 1 means no borrow); MUL = 1 iff the upper WIDTH bits of the full product are nonzero; all other ops 0.
REQ-024 overflow: ADD/SUB = carry into MSB XOR carry out of MSB; all other ops 0.
REQ-025 zero SHALL be (result == 0) and negative SHALL be result[WIDTH-1], for every opcode.
REQ-026 Throughput: one non-MUL op per 2 cycles at best (accept, then DONE handshake); back-to-back requests SHALL never be lost, only stalled.

Reset
REQ-027 While rst_n is low at a rising edge: state -> IDLE; out_valid, result, carry, overflow, zero, negative -> 0; in_ready SHALL be 0 while rst_n is low.
REQ-028 Reset during BUSY or DONE SHALL abandon the operation; its result SHALL never appear on the outputs.
REQ-029 First cycle after rst_n goes high: in_ready = 1, out_valid = 0.

Verification (WIDTH=8)
REQ-030 ADD a=0x7F b=0x01 -> next cycle out_valid=1, result=0x80, overflow=1, carry=0, negative=1, zero=0.
REQ-031 SUB a=0x05 b=0x05 -> result=0x00, zero=1, carry=1, overflow=0; SLT a=0x80 b=0x01 -> result=0x01; NAND a=0xF0 b=0xFF -> result=0x0F.
REQ-032 MUL a=0x10 b=0x11 -> out_valid exactly 8 cycles after accept, result=0x10, carry=1; in_ready=0 throughout BUSY and DONE.
REQ-033 Backpressure: out_ready=0 for 3 cycles in DONE, in_valid=1 with new operands -> result and flags unchanged, no accept; out_ready=1 -> handshake, in_ready=1 next cycle, pending request accepted.
REQ-034 rst_n low for 1 cycle at cycle 4 of a MUL -> all outputs 0 next cycle; in_ready=1 the cycle after; no out_valid from the abandoned MUL.
REQ-035 SLL a=0x81 b=0x09 (shift 1) -> result=0x02, carry=0; MUL a=0x00 b=0xFF -> result=0x00, zero=1, carry=0.
